spi_init_sequencer: RTL and testbench

Table-driven register initialisation sequencer sitting directly upstream of the SPI master that drives the display controller's serial port (SEN/SCK/SDAT). On a start pulse it walks an external init table, turning each entry into a single 16-bit SPI write or a timed delay. It signals completion to the top level. Optionally, it reads back every written register and flags mismatches.

---
 rtl/spi_init_sequencer.sv | 160 ++++++++++++++++
 tb/tb_spi_init_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_init_sequencer.sv
// Table-driven SPI register init sequencer: walks a ROM of write/delay/end entries.
// Optional read-back verification of every write is built when SPI_VERIFY_EN is defined.
module spi_init_sequencer #(
    parameter int unsigned ROM_ADDR_WIDTH = 6,
    parameter int unsigned DELAY_UNIT     = 1000
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_start,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_error,
    output logic [ROM_ADDR_WIDTH-1:0] o_romAddr,
    input  logic [15:0]               i_romData,
    output logic                      o_txBegin,
    output logic [6:0]                o_txAddress,
    output logic [7:0]                o_txData,
    input  logic                      i_txDone,
    output logic                      o_rxBegin,
    output logic [6:0]                o_rxAddress,
    input  logic [7:0]                i_rxData,
    input  logic                      i_rxDone
);

    // Wide enough for the largest delay field (0x7FFE) times DELAY_UNIT.
    localparam int unsigned   CntW = 15 + $clog2(DELAY_UNIT + 1);
    localparam logic [CntW-1:0] Unit = CntW'(DELAY_UNIT);

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StTxReq,
        StTxWait,
        StRxReq,
        StRxWait,
        StDelay,
        StNext,
        StDone
    } state_e;

    state_e                    state_q, state_d;
    logic [ROM_ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [6:0]                tx_addr_q, tx_addr_d;
    logic [7:0]                tx_data_q, tx_data_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic                      error_q, error_d;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= StIdle;
            rom_addr_q <= '0;
            tx_addr_q  <= '0;
            tx_data_q  <= '0;
            cnt_q      <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            tx_addr_q  <= tx_addr_d;
            tx_data_q  <= tx_data_d;
            cnt_q      <= cnt_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        tx_addr_d  = tx_addr_q;
        tx_data_d  = tx_data_q;
        cnt_d      = cnt_q;
        error_d    = error_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    rom_addr_d = '0;
                    error_d    = 1'b0;
                    state_d    = StFetch;
                end
            end
            StFetch: state_d = StDecode;
            StDecode: begin
                if (!i_romData[15]) begin
                    tx_addr_d = i_romData[14:8];
                    tx_data_d = i_romData[7:0];
                    state_d   = StTxReq;
                end else if (i_romData[14:0] == 15'h7FFF) begin
                    state_d = StDone;
                end else begin
                    cnt_d   = CntW'(i_romData[14:0]) * Unit;
                    state_d = StDelay;
                end
            end
            StTxReq: state_d = StTxWait;
            StTxWait: begin
                if (i_txDone) begin
`ifdef SPI_VERIFY_EN
                    state_d = StRxReq;
`else
                    state_d = StNext;
`endif
                end
            end
`ifdef SPI_VERIFY_EN
            StRxReq: state_d = StRxWait;
            StRxWait: begin
                if (i_rxDone) begin
                    if (i_rxData == tx_data_q) begin
                        state_d = StNext;
                    end else begin
                        error_d = 1'b1;
                        state_d = StDone;
                    end
                end
            end
`endif
            // A zero-length delay still spends one cycle here.
            StDelay: begin
                if (cnt_q <= CntW'(1)) begin
                    cnt_d   = '0;
                    state_d = StNext;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StNext: begin
                if (&rom_addr_q) begin
                    state_d = StDone;
                end else begin
                    rom_addr_d = rom_addr_q + ROM_ADDR_WIDTH'(1);
                    state_d    = StFetch;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign o_busy      = (state_q != StIdle) && (state_q != StDone);
    assign o_done      = (state_q == StDone);
    assign o_romAddr   = rom_addr_q;
    assign o_txBegin   = (state_q == StTxReq);
    assign o_txAddress = tx_addr_q;
    assign o_txData    = tx_data_q;

`ifdef SPI_VERIFY_EN
    assign o_rxBegin   = (state_q == StRxReq);
    assign o_rxAddress = tx_addr_q;
    assign o_error     = error_q;
`else
    assign o_rxBegin   = 1'b0;
    assign o_rxAddress = '0;
    assign o_error     = 1'b0;

    logic unused_rx;
    assign unused_rx = ^{i_rxData, i_rxDone, error_q};
`endif

endmodule

// File: tb/tb_spi_init_sequencer.sv
// Self-checking bench for spi_init_sequencer: directed table scenarios plus randomized
// tables checked against a cycle-count model derived from the entry rules.
module tb_spi_init_sequencer;

    localparam int AW     = 2;
    localparam int NumEnt = 4;
    localparam int Du     = 10;
`ifdef SPI_VERIFY_EN
    localparam bit Verify = 1'b1;
`else
    localparam bit Verify = 1'b0;
`endif

    logic          i_clock, i_reset, i_start;
    logic          o_busy, o_done, o_error;
    logic [AW-1:0] o_romAddr;
    logic [15:0]   i_romData;
    logic          o_txBegin, i_txDone, o_rxBegin, i_rxDone;
    logic [6:0]    o_txAddress, o_rxAddress;
    logic [7:0]    o_txData, i_rxData;

    spi_init_sequencer #(
        .ROM_ADDR_WIDTH(AW),
        .DELAY_UNIT    (Du)
    ) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_error    (o_error),
        .o_romAddr  (o_romAddr),
        .i_romData  (i_romData),
        .o_txBegin  (o_txBegin),
        .o_txAddress(o_txAddress),
        .o_txData   (o_txData),
        .i_txDone   (i_txDone),
        .o_rxBegin  (o_rxBegin),
        .o_rxAddress(o_rxAddress),
        .i_rxData   (i_rxData),
        .i_rxDone   (i_rxDone)
    );

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    // Synchronous ROM: data valid the cycle after the address changes.
    logic [15:0] rom [NumEnt];
    always_ff @(posedge i_clock) i_romData <= rom[o_romAddr];

    logic [28:0] out_vec;
    assign out_vec = {o_busy, o_done, o_error, o_txBegin, o_rxBegin, o_romAddr,
                      o_txAddress, o_txData, o_rxAddress};

    // SPI master stand-in: done pulse tx_lat / rx_lat cycles after the begin pulse.
    int         tx_lat = 1, rx_lat = 1;
    bit         corrupt = 1'b0;
    logic [7:0] last_data;
    initial begin
        i_txDone  = 1'b0;
        i_rxDone  = 1'b0;
        i_rxData  = '0;
        last_data = '0;
        forever begin
            @(negedge i_clock);
            i_txDone = 1'b0;
            i_rxDone = 1'b0;
            if (o_txBegin) begin
                last_data = o_txData;
                repeat (tx_lat) @(negedge i_clock);
                i_txDone = 1'b1;
            end else if (o_rxBegin) begin
                repeat (rx_lat) @(negedge i_clock);
                i_rxData = corrupt ? (last_data ^ 8'h01) : last_data;
                i_rxDone = 1'b1;
            end
        end
    end

    int errors = 0, checks = 0;

    // Observed run.
    logic [14:0] got_wr[$];
    logic [6:0]  got_rx[$];
    int          done_cnt, done_off, busy_bad, proto_bad, final_addr;
    bit          timed_out;
    logic        err_at_done;

    // Expected run.
    logic [14:0] exp_wr[$];
    logic [6:0]  exp_rx[$];
    int          exp_done, exp_addr;
    bit          exp_err;

    // Cycle budget per entry: FETCH+DECODE, then the entry's work, then NEXT.
    // Cycle 0 is the start cycle, so the first FETCH is cycle 1.
    task automatic model();
        int          t, n;
        logic [15:0] e;
        exp_wr.delete();
        exp_rx.delete();
        exp_err  = 1'b0;
        exp_addr = NumEnt - 1;
        exp_done = -1;
        t        = 1;
        for (int k = 0; k < NumEnt; k++) begin
            e = rom[k];
            if (e == 16'hFFFF) begin
                exp_done = t + 2;
                exp_addr = k;
                break;
            end else if (e[15]) begin
                n = int'(e[14:0]) * Du;
                t += 3 + ((n < 1) ? 1 : n);
            end else begin
                exp_wr.push_back(e[14:0]);
                t += 3 + tx_lat;
                if (Verify) begin
                    exp_rx.push_back(e[14:8]);
                    t += 1 + rx_lat;
                    if (corrupt) begin
                        exp_err  = 1'b1;
                        exp_done = t;
                        exp_addr = k;
                        break;
                    end
                end
                t += 1;
            end
        end
        if (exp_done < 0) exp_done = t;
    endtask

    task automatic run_seq(input int max_cyc, input int stop_tx, input bit poke);
        bit ptx, prx;
        got_wr.delete();
        got_rx.delete();
        done_cnt = 0; done_off = -1; busy_bad = 0; proto_bad = 0; final_addr = -1;
        err_at_done = 1'b0;
        timed_out = 1'b1;
        ptx = 1'b0;
        prx = 1'b0;
        @(negedge i_clock);
        i_start = 1'b1;
        @(negedge i_clock);
        i_start = 1'b0;
        for (int t = 1; t <= max_cyc; t++) begin
            if ((o_txBegin && o_rxBegin) || (o_txBegin && ptx) || (o_rxBegin && prx))
                proto_bad++;
            ptx = o_txBegin;
            prx = o_rxBegin;
            if (o_txBegin) got_wr.push_back({o_txAddress, o_txData});
            if (o_rxBegin) got_rx.push_back(o_rxAddress);
            if (o_done) begin
                done_cnt++;
                done_off    = t;
                final_addr  = int'(o_romAddr);
                err_at_done = o_error;
                if (o_busy) busy_bad++;
                timed_out = 1'b0;
                break;
            end
            if (!o_busy) busy_bad++;
            if (stop_tx > 0 && got_wr.size() >= stop_tx) begin
                timed_out = 1'b0;
                break;
            end
            i_start = poke && (t % 5 == 2);
            @(negedge i_clock);
        end
        i_start = 1'b0;
        if (stop_tx == 0) begin
            repeat (4) begin
                @(negedge i_clock);
                if (o_done) done_cnt++;
                if (o_txBegin) got_wr.push_back({o_txAddress, o_txData});
            end
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) @(negedge i_clock);
        checks++; if (out_vec !== 29'h0) begin errors++;
            $display("FAIL reset_outputs: got %h want 0", out_vec); end
        i_reset = 1'b0;
        repeat (3) @(negedge i_clock);
        checks++; if (o_busy !== 1'b0) begin errors++;
            $display("FAIL idle_no_start_busy: got %b want 0", o_busy); end
    endtask

    task automatic test_two_writes();
        rom = '{16'h0512, 16'h0A34, 16'hFFFF, 16'h0000};
        tx_lat = 40; rx_lat = 3; corrupt = 1'b0;
        model();
        run_seq(600, 0, 1'b0);
        checks++; if (timed_out) begin errors++;
            $display("FAIL two_writes_timeout: got timeout want done"); end
        checks++; if (got_wr.size() !== 2) begin errors++;
            $display("FAIL two_writes_count: got %0d want 2", got_wr.size()); end
        checks++; if ((got_wr.size() > 0 ? got_wr[0] : 15'hx) !== {7'h05, 8'h12}) begin errors++;
            $display("FAIL two_writes_first: got %h want %h", got_wr[0], {7'h05, 8'h12}); end
        checks++; if ((got_wr.size() > 1 ? got_wr[1] : 15'hx) !== {7'h0A, 8'h34}) begin errors++;
            $display("FAIL two_writes_second: got %h want %h", got_wr[1], {7'h0A, 8'h34}); end
        checks++; if (done_cnt !== 1) begin errors++;
            $display("FAIL two_writes_done_count: got %0d want 1", done_cnt); end
        checks++; if (done_off !== exp_done) begin errors++;
            $display("FAIL two_writes_done_cycle: got %0d want %0d", done_off, exp_done); end
        checks++; if (busy_bad !== 0 || proto_bad !== 0) begin errors++;
            $display("FAIL two_writes_busy_proto: got %0d/%0d want 0/0", busy_bad, proto_bad); end
        checks++; if (err_at_done !== 1'b0) begin errors++;
            $display("FAIL two_writes_error: got %b want 0", err_at_done); end
    endtask

    task automatic test_delay();
        // 3-tick delay: FETCH,DECODE (1..2), DELAY 30 cycles (3..32), NEXT,FETCH,DECODE, DONE@36.
        rom = '{16'h8003, 16'hFFFF, 16'h0000, 16'h0000};
        run_seq(200, 0, 1'b0);
        checks++; if (got_wr.size() !== 0) begin errors++;
            $display("FAIL delay_no_tx: got %0d writes want 0", got_wr.size()); end
        checks++; if (done_off !== 36) begin errors++;
            $display("FAIL delay_done_cycle: got %0d want 36", done_off); end
        // Zero-tick delay still takes one DELAY cycle: done at 1+3+1+2.
        rom = '{16'h8000, 16'hFFFF, 16'h0000, 16'h0000};
        run_seq(200, 0, 1'b0);
        checks++; if (done_off !== 7) begin errors++;
            $display("FAIL zero_delay_done_cycle: got %0d want 7", done_off); end
    endtask

    task automatic test_full_table();
        rom = '{16'h0111, 16'h0222, 16'h0333, 16'h0444};
        tx_lat = 2; corrupt = 1'b0;
        model();
        run_seq(300, 0, 1'b0);
        checks++; if (got_wr.size() !== 4) begin errors++;
            $display("FAIL full_count: got %0d want 4", got_wr.size()); end
        checks++; if ((got_wr.size() > 3 ? got_wr[3] : 15'hx) !== {7'h04, 8'h44}) begin errors++;
            $display("FAIL full_last_write: got %h want %h", got_wr[3], {7'h04, 8'h44}); end
        checks++; if (final_addr !== 3 || o_romAddr !== 2'd3) begin errors++;
            $display("FAIL full_rom_addr: got %0d/%0d want 3", final_addr, o_romAddr); end
        checks++; if (done_off !== exp_done || done_cnt !== 1) begin errors++;
            $display("FAIL full_done: got %0d x%0d want %0d x1", done_off, done_cnt, exp_done); end
    endtask

    task automatic test_reset_in_tx_wait();
        int bad;
        rom = '{16'h0111, 16'h0222, 16'h0333, 16'hFFFF};
        tx_lat = 40; corrupt = 1'b0;
        run_seq(300, 2, 1'b0);
        checks++; if (timed_out || o_romAddr !== 2'd1) begin errors++;
            $display("FAIL rst_reach_entry1: got addr %0d want 1", o_romAddr); end
        repeat (5) @(negedge i_clock);
        i_reset = 1'b1;
        @(negedge i_clock);
        i_reset = 1'b0;
        checks++; if (out_vec !== 29'h0) begin errors++;
            $display("FAIL rst_in_wait_outputs: got %h want 0", out_vec); end
        bad = 0;
        repeat (50) begin
            @(negedge i_clock);
            if (o_busy || o_done || o_txBegin) bad++;
        end
        checks++; if (bad !== 0) begin errors++;
            $display("FAIL rst_late_done_ignored: got %0d active cycles want 0", bad); end
        tx_lat = 3;
        model();
        run_seq(300, 0, 1'b0);
        checks++; if ((got_wr.size() > 0 ? got_wr[0] : 15'hx) !== {7'h01, 8'h11}) begin errors++;
            $display("FAIL rst_restart_entry0: got %h want %h", got_wr[0], {7'h01, 8'h11}); end
        checks++; if (got_wr.size() !== 3 || done_off !== exp_done) begin errors++;
            $display("FAIL rst_restart_run: got %0d writes done@%0d want 3 done@%0d",
                     got_wr.size(), done_off, exp_done); end
    endtask

    task automatic test_start_while_busy();
        rom = '{16'h0512, 16'h8001, 16'h0A34, 16'hFFFF};
        tx_lat = 5; corrupt = 1'b0;
        model();
        run_seq(400, 0, 1'b1);
        checks++; if (got_wr.size() !== 2 || done_cnt !== 1) begin errors++;
            $display("FAIL busy_start_seq: got %0d writes %0d dones want 2 1",
                     got_wr.size(), done_cnt); end
        checks++; if (done_off !== exp_done || final_addr !== 3) begin errors++;
            $display("FAIL busy_start_timing: got done@%0d addr %0d want done@%0d addr 3",
                     done_off, final_addr, exp_done); end
    endtask

    task automatic test_verify_mismatch();
        rom = '{16'h0512, 16'h0A34, 16'hFFFF, 16'h0000};
        tx_lat = 4; rx_lat = 3; corrupt = 1'b1;
        model();
        run_seq(400, 0, 1'b0);
        checks++; if (got_rx.size() !== exp_rx.size()) begin errors++;
            $display("FAIL vfy_rx_count: got %0d want %0d", got_rx.size(), exp_rx.size()); end
        checks++; if (Verify && (got_rx.size() > 0 ? got_rx[0] : 7'hx) !== 7'h05) begin errors++;
            $display("FAIL vfy_rx_addr: got %h want 05", got_rx[0]); end
        checks++; if (got_wr.size() !== exp_wr.size()) begin errors++;
            $display("FAIL vfy_write_count: got %0d want %0d", got_wr.size(), exp_wr.size()); end
        checks++; if (err_at_done !== exp_err || done_off !== exp_done) begin errors++;
            $display("FAIL vfy_err_done: got err %b done@%0d want err %b done@%0d",
                     err_at_done, done_off, exp_err, exp_done); end
        checks++; if (o_error !== exp_err) begin errors++;
            $display("FAIL vfy_err_sticky: got %b want %b", o_error, exp_err); end
        corrupt = 1'b0;
        run_seq(400, 0, 1'b0);
        checks++; if (err_at_done !== 1'b0 || o_error !== 1'b0) begin errors++;
            $display("FAIL vfy_err_cleared: got %b/%b want 0", err_at_done, o_error); end
    endtask

    task automatic test_random();
        int          r;
        logic [14:0] g;
        for (int it = 0; it < 15; it++) begin
            for (int k = 0; k < NumEnt; k++) begin
                r = int'($urandom_range(0, 9));
                if (r < 6) rom[k] = {1'b0, 15'($urandom())};
                else if (r < 8 || k == 0) rom[k] = {1'b1, 15'($urandom_range(0, 4))};
                else rom[k] = 16'hFFFF;
            end
            tx_lat  = int'($urandom_range(1, 6));
            rx_lat  = int'($urandom_range(1, 6));
            corrupt = ($urandom_range(0, 3) == 0);
            model();
            run_seq(2000, 0, $urandom_range(0, 1) == 1);
            checks++; if (got_wr.size() !== exp_wr.size()) begin errors++;
                $display("FAIL rnd%0d_writes: got %0d want %0d", it, got_wr.size(),
                         exp_wr.size()); end
            foreach (exp_wr[i]) begin
                g = (i < got_wr.size()) ? got_wr[i] : 15'hx;
                checks++; if (g !== exp_wr[i]) begin errors++;
                    $display("FAIL rnd%0d_write%0d: got %h want %h", it, i, g, exp_wr[i]); end
            end
            checks++; if (got_rx.size() !== exp_rx.size()) begin errors++;
                $display("FAIL rnd%0d_reads: got %0d want %0d", it, got_rx.size(),
                         exp_rx.size()); end
            checks++; if (done_off !== exp_done || done_cnt !== 1) begin errors++;
                $display("FAIL rnd%0d_done: got @%0d x%0d want @%0d x1", it, done_off,
                         done_cnt, exp_done); end
            checks++; if (final_addr !== exp_addr || err_at_done !== exp_err) begin errors++;
                $display("FAIL rnd%0d_end_state: got addr %0d err %b want addr %0d err %b",
                         it, final_addr, err_at_done, exp_addr, exp_err); end
            checks++; if (busy_bad !== 0 || proto_bad !== 0) begin errors++;
                $display("FAIL rnd%0d_busy_proto: got %0d/%0d want 0/0", it, busy_bad,
                         proto_bad); end
        end
        corrupt = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1;
        i_start = 1'b0;
        for (int k = 0; k < NumEnt; k++) rom[k] = 16'hFFFF;
        test_reset();
        test_two_writes();
        test_delay();
        test_full_table();
        test_reset_in_tx_wait();
        test_start_while_busy();
        test_verify_mismatch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
